// File: rtl/udp_pkt_pkg.sv
// ============================================================================
// Module      : udp_pkt_pkg
// Description : Shared types and constants for the UDP transmit packetizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package udp_pkt_pkg;

   typedef enum logic [1:0] {
      ST_FILL    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2
   } pkt_state_t;

   localparam logic [15:0] UDP_HDR_LEN = 16'd8;
   localparam logic [7:0]  DEFAULT_TTL = 8'd64;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_byte.sv
// ============================================================================
// Module      : sync_fifo_byte
// Description : Single-clock FIFO with a registered first-word-fall-through
//               output stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_byte #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_wr_en,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   output logic                  o_full,
   input  logic                  i_rd_en,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]           r_wr_ptr;
   logic [AW:0]           r_rd_ptr;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_dout_valid;

   logic w_mem_empty;
   logic w_full;
   logic w_wr;
   logic w_load;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_wr        = i_wr_en && !w_full;
   assign w_load      = !w_mem_empty && (!r_dout_valid || i_rd_en);

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
      end
      if (w_load) begin
         r_dout <= r_mem[r_rd_ptr[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_dout_valid <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_load) begin
            r_rd_ptr     <= r_rd_ptr + 1'b1;
            r_dout_valid <= 1'b1;
         end else if (i_rd_en) begin
            r_dout_valid <= 1'b0;
         end
      end
   end

   assign o_full    = w_full;
   assign o_rd_data = r_dout;
   assign o_empty   = !r_dout_valid;

endmodule

`default_nettype wire

// File: rtl/udp_axis_packetizer.sv
// ============================================================================
// Module      : udp_axis_packetizer
// Description : Buffers a raw AXI-Stream byte stream and emits it as UDP
//               datagrams (header + payload) on fill, tlast or idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_axis_packetizer
   import udp_pkt_pkg::*;
#(
   parameter logic [15:0] UDP_PORT       = 16'd1234,
   parameter int          MAX_PAYLOAD    = 1024,
   parameter int          TIMEOUT_CYCLES = 125000,
   parameter logic [7:0]  IP_TTL         = DEFAULT_TTL
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_axis_tdata,
   input  logic        in_axis_tvalid,
   output logic        in_axis_tready,
   input  logic        in_axis_tlast,
   input  logic        in_axis_tuser,
   output logic        udp_tx_hdr_valid,
   input  logic        udp_tx_hdr_ready,
   output logic [5:0]  udp_tx_ip_dscp,
   output logic [1:0]  udp_tx_ip_ecn,
   output logic [7:0]  udp_tx_ip_ttl,
   output logic [31:0] udp_tx_ip_source_ip,
   output logic [31:0] udp_tx_ip_dest_ip,
   output logic [15:0] udp_tx_udp_source_port,
   output logic [15:0] udp_tx_udp_dest_port,
   output logic [15:0] udp_tx_udp_length,
   output logic [15:0] udp_tx_udp_checksum,
   output logic [7:0]  udp_tx_payload_tdata,
   output logic        udp_tx_payload_tvalid,
   input  logic        udp_tx_payload_tready,
   output logic        udp_tx_payload_tlast,
   output logic        udp_tx_payload_tuser,
   input  logic [31:0] local_ip,
   input  logic [31:0] dest_ip,
   input  logic [15:0] dest_port,
   output logic [31:0] packet_count,
   output logic        busy
);

   localparam int CW = $clog2(MAX_PAYLOAD) + 1;
   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] C_MAX       = CW'(MAX_PAYLOAD);
   localparam logic [IW-1:0] C_IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

   pkt_state_t r_state;
   pkt_state_t w_state_nxt;

   logic [CW-1:0] r_count;
   logic [IW-1:0] r_idle;
   logic [CW-1:0] r_len;
   logic [CW-1:0] r_beat;
   logic [31:0]   r_dest_ip;
   logic [15:0]   r_dest_port;
   logic [31:0]   r_packet_count;

   logic          w_in_ready;
   logic          w_accept;
   logic [CW-1:0] w_count_inc;
   logic          w_flush;
   logic          w_hdr_valid;
   logic          w_fifo_empty;
   logic          w_fifo_full;
   logic [7:0]    w_fifo_data;
   logic          w_pay_valid;
   logic          w_pay_last;
   logic          w_pay_fire;
   logic          w_unused;

   assign w_unused    = in_axis_tuser ^ w_fifo_full;

   assign w_in_ready  = !reset && (r_state == ST_FILL) && (r_count < C_MAX);
   assign w_accept    = in_axis_tvalid && w_in_ready;
   assign w_count_inc = r_count + CW'(1);

   // The idle trigger only applies on cycles with no beat, since a beat clears it.
   assign w_flush = (w_accept && (in_axis_tlast || (w_count_inc == C_MAX))) ||
                    (!w_accept && (r_count != '0) && (r_idle == C_IDLE_LAST));

   assign w_pay_valid = (r_state == ST_PAYLOAD) && !w_fifo_empty;
   assign w_pay_last  = (r_beat == r_len);
   assign w_pay_fire  = w_pay_valid && udp_tx_payload_tready;

   sync_fifo_byte #(
      .DATA_WIDTH (8),
      .DEPTH      (MAX_PAYLOAD)
   ) u_fifo (
      .clk       (clk),
      .rst       (reset),
      .i_wr_en   (w_accept),
      .i_wr_data (in_axis_tdata),
      .o_full    (w_fifo_full),
      .i_rd_en   (w_pay_fire),
      .o_rd_data (w_fifo_data),
      .o_empty   (w_fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_hdr_valid = 1'b0;
      case (r_state)
         ST_FILL: begin
            if (w_flush) begin
               w_state_nxt = ST_HDR;
            end
         end
         ST_HDR: begin
            w_hdr_valid = 1'b1;
            if (udp_tx_hdr_ready) begin
               w_state_nxt = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (w_pay_fire && w_pay_last) begin
               w_state_nxt = ST_FILL;
            end
         end
         default: w_state_nxt = ST_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count        <= '0;
         r_idle         <= '0;
         r_len          <= '0;
         r_beat         <= '0;
         r_dest_ip      <= '0;
         r_dest_port    <= '0;
         r_packet_count <= '0;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (w_accept) begin
                  r_count <= w_count_inc;
                  r_idle  <= '0;
               end else if ((r_count != '0) && (r_idle != '1)) begin
                  r_idle <= r_idle + IW'(1);
               end
               if (w_flush) begin
                  r_len       <= w_accept ? w_count_inc : r_count;
                  r_dest_ip   <= dest_ip;
                  r_dest_port <= dest_port;
                  r_idle      <= '0;
               end
            end
            ST_HDR: begin
               r_beat <= CW'(1);
            end
            ST_PAYLOAD: begin
               if (w_pay_fire) begin
                  r_beat <= r_beat + CW'(1);
                  if (w_pay_last) begin
                     r_packet_count <= r_packet_count + 32'd1;
                     r_count        <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign in_axis_tready         = w_in_ready;
   assign udp_tx_hdr_valid       = w_hdr_valid;
   assign udp_tx_ip_dscp         = 6'd0;
   assign udp_tx_ip_ecn          = 2'd0;
   assign udp_tx_ip_ttl          = IP_TTL;
   assign udp_tx_ip_source_ip    = local_ip;
   assign udp_tx_ip_dest_ip      = r_dest_ip;
   assign udp_tx_udp_source_port = UDP_PORT;
   assign udp_tx_udp_dest_port   = r_dest_port;
   assign udp_tx_udp_length      = 16'(r_len) + UDP_HDR_LEN;
   assign udp_tx_udp_checksum    = 16'd0;
   assign udp_tx_payload_tdata   = w_fifo_data;
   assign udp_tx_payload_tvalid  = w_pay_valid;
   assign udp_tx_payload_tlast   = w_pay_valid && w_pay_last;
   assign udp_tx_payload_tuser   = 1'b0;
   assign packet_count           = r_packet_count;
   assign busy                   = (r_state != ST_FILL);

endmodule

`default_nettype wire

// File: tb/tb_udp_axis_packetizer.sv
// ============================================================================
// Module      : tb_udp_axis_packetizer
// Description : Directed, table-driven self-checking bench for the packetizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_udp_axis_packetizer;

   localparam int MAXP    = 16;
   localparam int TIMEOUT = 100;
   localparam int LIMIT   = 3000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_axis_tdata = '0;
   logic        in_axis_tvalid = 1'b0;
   logic        in_axis_tready;
   logic        in_axis_tlast = 1'b0;
   logic        in_axis_tuser = 1'b0;
   logic        udp_tx_hdr_valid;
   logic        udp_tx_hdr_ready = 1'b0;
   logic [5:0]  udp_tx_ip_dscp;
   logic [1:0]  udp_tx_ip_ecn;
   logic [7:0]  udp_tx_ip_ttl;
   logic [31:0] udp_tx_ip_source_ip;
   logic [31:0] udp_tx_ip_dest_ip;
   logic [15:0] udp_tx_udp_source_port;
   logic [15:0] udp_tx_udp_dest_port;
   logic [15:0] udp_tx_udp_length;
   logic [15:0] udp_tx_udp_checksum;
   logic [7:0]  udp_tx_payload_tdata;
   logic        udp_tx_payload_tvalid;
   logic        udp_tx_payload_tready = 1'b0;
   logic        udp_tx_payload_tlast;
   logic        udp_tx_payload_tuser;
   logic [31:0] local_ip = 32'h0A00_0001;
   logic [31:0] dest_ip = '0;
   logic [15:0] dest_port = '0;
   logic [31:0] packet_count;
   logic        busy;

   udp_axis_packetizer #(
      .UDP_PORT       (16'd1234),
      .MAX_PAYLOAD    (MAXP),
      .TIMEOUT_CYCLES (TIMEOUT),
      .IP_TTL         (8'd64)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .in_axis_tdata          (in_axis_tdata),
      .in_axis_tvalid         (in_axis_tvalid),
      .in_axis_tready         (in_axis_tready),
      .in_axis_tlast          (in_axis_tlast),
      .in_axis_tuser          (in_axis_tuser),
      .udp_tx_hdr_valid       (udp_tx_hdr_valid),
      .udp_tx_hdr_ready       (udp_tx_hdr_ready),
      .udp_tx_ip_dscp         (udp_tx_ip_dscp),
      .udp_tx_ip_ecn          (udp_tx_ip_ecn),
      .udp_tx_ip_ttl          (udp_tx_ip_ttl),
      .udp_tx_ip_source_ip    (udp_tx_ip_source_ip),
      .udp_tx_ip_dest_ip      (udp_tx_ip_dest_ip),
      .udp_tx_udp_source_port (udp_tx_udp_source_port),
      .udp_tx_udp_dest_port   (udp_tx_udp_dest_port),
      .udp_tx_udp_length      (udp_tx_udp_length),
      .udp_tx_udp_checksum    (udp_tx_udp_checksum),
      .udp_tx_payload_tdata   (udp_tx_payload_tdata),
      .udp_tx_payload_tvalid  (udp_tx_payload_tvalid),
      .udp_tx_payload_tready  (udp_tx_payload_tready),
      .udp_tx_payload_tlast   (udp_tx_payload_tlast),
      .udp_tx_payload_tuser   (udp_tx_payload_tuser),
      .local_ip               (local_ip),
      .dest_ip                (dest_ip),
      .dest_port              (dest_port),
      .packet_count           (packet_count),
      .busy                   (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  dscp;
      logic [1:0]  ecn;
      logic [7:0]  ttl;
      logic [31:0] sip;
      logic [31:0] dip;
      logic [15:0] sport;
      logic [15:0] dport;
      logic [15:0] ulen;
      logic [15:0] csum;
   } hdr_t;

   typedef struct {
      int          n;
      logic [7:0]  first;
      bit          tl;
      logic [31:0] dip;
      logic [15:0] dport;
      int          hdr_delay;
      bit          rnd;
      bit          timing;
      int          npk;
      int          ul0;
      int          ul1;
      int          ul2;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int hv_rise_cyc = 0;
   int exp_pc = 0;
   int hdr_delay = 0;
   bit rnd_ready = 1'b0;

   hdr_t       hdr_q[$];
   int         plen_q[$];
   logic [7:0] byte_q[$];
   int         cur_len = 0;
   int         hdr_wait = 0;
   bit         prev_stall = 1'b0;
   logic [143:0] prev_hdr_bits = '0;
   logic [143:0] hdr_bits;

   assign hdr_bits = {udp_tx_ip_dscp, udp_tx_ip_ecn, udp_tx_ip_ttl, udp_tx_ip_source_ip,
                      udp_tx_ip_dest_ip, udp_tx_udp_source_port, udp_tx_udp_dest_port,
                      udp_tx_udp_length, udp_tx_udp_checksum};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Sink model: drives hdr_ready/payload tready and logs every handshake.
   always @(negedge clk) begin
      if (reset) begin
         hdr_wait   = 0;
         prev_stall = 1'b0;
         cur_len    = 0;
         hdr_q.delete();
         plen_q.delete();
         byte_q.delete();
      end else begin
         if (busy) chk("in_tready_while_busy", 160'(in_axis_tready), 160'(0));
         if (udp_tx_hdr_valid) begin
            if (!prev_stall && hdr_wait == 0) hv_rise_cyc = cyc;
            if (prev_stall) chk("hdr_stable", 160'(hdr_bits), 160'(prev_hdr_bits));
            if (hdr_wait >= hdr_delay) begin
               udp_tx_hdr_ready = 1'b1;
               hdr_q.push_back('{udp_tx_ip_dscp, udp_tx_ip_ecn, udp_tx_ip_ttl,
                                 udp_tx_ip_source_ip, udp_tx_ip_dest_ip,
                                 udp_tx_udp_source_port, udp_tx_udp_dest_port,
                                 udp_tx_udp_length, udp_tx_udp_checksum});
               hdr_wait   = 0;
               prev_stall = 1'b0;
            end else begin
               udp_tx_hdr_ready = 1'b0;
               hdr_wait++;
               prev_stall    = 1'b1;
               prev_hdr_bits = hdr_bits;
            end
         end else begin
            udp_tx_hdr_ready = 1'b0;
            hdr_wait   = 0;
            prev_stall = 1'b0;
         end
         udp_tx_payload_tready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (udp_tx_payload_tvalid && udp_tx_payload_tready) begin
            chk("payload_tuser", 160'(udp_tx_payload_tuser), 160'(0));
            byte_q.push_back(udp_tx_payload_tdata);
            cur_len++;
            if (udp_tx_payload_tlast) begin
               plen_q.push_back(cur_len);
               cur_len = 0;
            end
         end
      end
   end

   task automatic send_bytes(input int n, input logic [7:0] first, input bit tl);
      int guard;
      for (int i = 0; i < n; i++) begin
         in_axis_tvalid = 1'b1;
         in_axis_tdata  = 8'(first + 8'(i));
         in_axis_tuser  = in_axis_tdata[0];
         in_axis_tlast  = tl && (i == n - 1);
         guard = 0;
         while (in_axis_tready !== 1'b1 && guard < LIMIT) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= LIMIT) begin
            checks++;
            failures++;
            $display("FAIL send_timeout byte=%0d actual=stalled required=accepted", i);
         end
         acc_cyc = cyc + 1;
         @(negedge clk);
      end
      in_axis_tvalid = 1'b0;
      in_axis_tlast  = 1'b0;
   endtask

   task automatic wait_pkts(input int n);
      int guard = 0;
      while ((plen_q.size() < n || hdr_q.size() < n) && guard < LIMIT) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= LIMIT) begin
         checks++;
         failures++;
         $display("FAIL wait_datagram actual=%0d required=%0d", plen_q.size(), n);
      end
   endtask

   task automatic check_pkt(input int ulen, input logic [31:0] dip, input logic [15:0] dport,
                            input logic [7:0] base);
      hdr_t       h;
      int         plen;
      int         errs;
      logic [7:0] b;
      if (hdr_q.size() == 0 || plen_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL datagram_missing actual=none required=udp_length %0d", ulen);
         return;
      end
      h = hdr_q.pop_front();
      chk("udp_length",  160'(h.ulen),  160'(ulen));
      chk("ip_dest_ip",  160'(h.dip),   160'(dip));
      chk("udp_dest",    160'(h.dport), 160'(dport));
      chk("udp_src",     160'(h.sport), 160'(16'd1234));
      chk("ip_ttl",      160'(h.ttl),   160'(8'd64));
      chk("ip_src_ip",   160'(h.sip),   160'(32'h0A00_0001));
      chk("udp_csum",    160'(h.csum),  160'(0));
      chk("ip_dscp_ecn", 160'({h.dscp, h.ecn}), 160'(0));
      plen = plen_q.pop_front();
      chk("payload_len", 160'(plen), 160'(ulen - 8));
      errs = 0;
      for (int j = 0; j < plen; j++) begin
         if (byte_q.size() == 0) begin
            errs++;
            break;
         end
         b = byte_q.pop_front();
         if (b !== 8'(base + 8'(j))) errs++;
      end
      chk("payload_bytes_bad", 160'(errs), 160'(0));
   endtask

   function automatic int pick_ul(input vec_t v, input int k);
      return (k == 0) ? v.ul0 : (k == 1) ? v.ul1 : v.ul2;
   endfunction

   task automatic apply_row(input vec_t v);
      int off = 0;
      int ul;
      dest_ip   = v.dip;
      dest_port = v.dport;
      hdr_delay = v.hdr_delay;
      rnd_ready = v.rnd;
      send_bytes(v.n, v.first, v.tl);
      wait_pkts(v.npk);
      if (v.timing) chk("timeout_latency", 160'(hv_rise_cyc - acc_cyc), 160'(TIMEOUT));
      for (int k = 0; k < v.npk; k++) begin
         ul = pick_ul(v, k);
         check_pkt(ul, v.dip, v.dport, 8'(v.first + 8'(off)));
         off += ul - 8;
      end
      @(negedge clk);
      @(negedge clk);
      exp_pc += v.npk;
      chk("packet_count", 160'(packet_count), 160'(exp_pc));
   endtask

   vec_t vecs[7];

   initial begin
      int guard;
      vecs[0] = '{5,  8'h01, 1'b1, 32'hC0A8_0102, 16'd5000, 0,  1'b0, 1'b0, 1, 13, 0,  0};
      vecs[1] = '{40, 8'h10, 1'b0, 32'hC0A8_0103, 16'd5001, 0,  1'b1, 1'b0, 3, 24, 24, 16};
      vecs[2] = '{3,  8'h60, 1'b0, 32'hC0A8_0104, 16'd5002, 0,  1'b0, 1'b1, 1, 11, 0,  0};
      vecs[3] = '{10, 8'h70, 1'b1, 32'hC0A8_0105, 16'd5003, 50, 1'b1, 1'b0, 1, 18, 0,  0};
      vecs[4] = '{16, 8'h80, 1'b1, 32'hC0A8_0106, 16'd5004, 0,  1'b1, 1'b0, 1, 24, 0,  0};
      vecs[5] = '{1,  8'h90, 1'b1, 32'hC0A8_0108, 16'd5006, 0,  1'b0, 1'b0, 1, 9,  0,  0};
      vecs[6] = '{4,  8'hA0, 1'b1, 32'hC0A8_0107, 16'd5005, 0,  1'b1, 1'b0, 1, 12, 0,  0};

      repeat (3) @(negedge clk);
      chk("rst_in_tready",  160'(in_axis_tready),        160'(0));
      chk("rst_hdr_valid",  160'(udp_tx_hdr_valid),      160'(0));
      chk("rst_tvalid",     160'(udp_tx_payload_tvalid), 160'(0));
      chk("rst_tlast",      160'(udp_tx_payload_tlast),  160'(0));
      chk("rst_tuser",      160'(udp_tx_payload_tuser),  160'(0));
      chk("rst_pkt_count",  160'(packet_count),          160'(0));
      chk("rst_busy",       160'(busy),                  160'(0));
      reset = 1'b0;
      #1;
      chk("fill_in_tready", 160'(in_axis_tready), 160'(1));
      @(negedge clk);

      for (int r = 0; r < 6; r++) apply_row(vecs[r]);

      // Destination changes while a datagram is streaming out.
      dest_ip = 32'hC0A8_0005;
      dest_port = 16'd7000;
      hdr_delay = 0;
      rnd_ready = 1'b1;
      send_bytes(6, 8'h40, 1'b1);
      guard = 0;
      while (!udp_tx_payload_tvalid && guard < LIMIT) begin
         @(negedge clk);
         guard++;
      end
      dest_ip = 32'hC0A8_0099;
      dest_port = 16'd7777;
      wait_pkts(1);
      check_pkt(14, 32'hC0A8_0005, 16'd7000, 8'h40);
      @(negedge clk);
      send_bytes(2, 8'h50, 1'b1);
      wait_pkts(1);
      check_pkt(10, 32'hC0A8_0099, 16'd7777, 8'h50);
      @(negedge clk);
      @(negedge clk);
      exp_pc += 2;
      chk("packet_count_dest", 160'(packet_count), 160'(exp_pc));

      // Reset in the middle of a payload.
      rnd_ready = 1'b0;
      dest_ip = 32'hC0A8_00AA;
      dest_port = 16'd6000;
      send_bytes(10, 8'hB0, 1'b1);
      guard = 0;
      while (byte_q.size() < 3 && guard < LIMIT) begin
         @(negedge clk);
         guard++;
      end
      chk("mid_payload_reached", 160'(byte_q.size() >= 3), 160'(1));
      reset = 1'b1;
      #1;
      chk("mid_rst_in_tready", 160'(in_axis_tready), 160'(0));
      @(negedge clk);
      chk("mid_rst_hdr_valid", 160'(udp_tx_hdr_valid),      160'(0));
      chk("mid_rst_tvalid",    160'(udp_tx_payload_tvalid), 160'(0));
      chk("mid_rst_tlast",     160'(udp_tx_payload_tlast),  160'(0));
      chk("mid_rst_busy",      160'(busy),                  160'(0));
      chk("mid_rst_pkt_count", 160'(packet_count),          160'(0));
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_rst_in_tready", 160'(in_axis_tready), 160'(1));
      exp_pc = 0;
      @(negedge clk);
      apply_row(vecs[6]);
      chk("no_stray_bytes", 160'(byte_q.size()), 160'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "global timeout");
   end

endmodule

`default_nettype wire
